cache_lookup: RTL and testbench
===============================

CACHE_LOOKUP -- requirements
Module: cache_lookup

Interface
REQ-001 Parameters SHALL be: NUM_SETS, default 16384, number of sets; N_WAY, default 16, ways per set (power of 2, >=2); INDEX_SIZE, default 14, log2(NUM_SETS); TAG_SIZE, default 12, tag bits; CNT_W, default 32, statistics counter width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_cmd  input  4  command: 0 data read, 1 data write, 2 instruction read, 3 snoop invalidate, 8 clear; all other values unsupported.
REQ-007 req_index / req_tag  input  INDEX_SIZE / TAG_SIZE  set index and tag from the address-decode stage.
REQ-008 resp_valid  output  1  one-cycle response strobe.
REQ-009 resp_hit, resp_err  output  1 each  tag hit; unsupported command.
REQ-010 resp_way  output  log2(N_WAY)  way hit or allocated.
REQ-011 resp_evict, resp_evict_dirty  output  1 each  valid line replaced; replaced line was dirty.
REQ-012 resp_evict_tag  output  TAG_SIZE  tag of replaced line.
REQ-013 hit_cnt, miss_cnt, rd_cnt, wr_cnt  output  CNT_W each  statistics, saturating at all-ones.

Function
REQ-014 Storage SHALL be internal: per set, N_WAY entries {valid, dirty, tag} plus N_WAY-1 tree-PLRU bits.
REQ-015 FSM states SHALL be IDLE, LOOKUP, UPDATE, CLEAR; req_ready=1 only in IDLE.
REQ-016 Handshake: request accepted when req_valid & req_ready; index, tag, cmd registered; IDLE->LOOKUP, or IDLE->CLEAR for cmd 8.
REQ-017 LOOKUP SHALL compare tag against all valid ways of the set; hit = exactly-one match; record hit way, lowest-indexed invalid way, and PLRU victim; ->UPDATE.
REQ-018 UPDATE SHALL write arrays, drive resp_valid=1 for one cycle, ->IDLE; response fields valid only while resp_valid=1; latency acceptance-to-resp_valid = 2 cycles; next request acceptable the cycle after resp_valid.
REQ-019 PLRU tree: node i has children 2i+1, 2i+2; victim walk from root, bit 0 -> left, 1 -> right; on access to way w, each node on w's path set to point away from w (w left -> 1, w right -> 0).
REQ-020 cmd 0/2 hit: PLRU touched, no data-state change. cmd 1 hit: dirty=1, PLRU touched.
REQ-021 cmd 0/1/2 miss: allocate lowest invalid way if any (resp_evict=0), else PLRU victim (resp_evict=1, resp_evict_dirty/resp_evict_tag = old line); new line valid=1, tag=req_tag, dirty=(cmd==1); PLRU touched on allocated way.
REQ-022 cmd 3: hit -> valid=0, dirty=0, PLRU unchanged, resp_hit=1; miss -> no change; hit/miss counters unchanged.
REQ-023 Unsupported cmd: LOOKUP/UPDATE traversed, resp_err=1, resp_hit=0, no array or counter change.
REQ-024 Counters: cmd 0/2 -> rd_cnt+1; cmd 1 -> wr_cnt+1; cmd 0/1/2 -> hit_cnt or miss_cnt +1; all saturate, never wrap.
REQ-025 CLEAR SHALL walk sets 0..NUM_SETS-1, one per cycle, zeroing valid, dirty, tag and PLRU bits; after set NUM_SETS-1, ->UPDATE-style single resp_valid (resp_hit=0, resp_err=0), counters zeroed, ->IDLE.
REQ-026 Non-response outputs SHALL be 0 whenever resp_valid=0.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force state CLEAR with set counter 0, zero all counters and response outputs, and abort any in-flight request with no response.
REQ-028 After rst_n returns high, CLEAR completes (NUM_SETS cycles), then one resp_valid strobe, then req_ready=1; reset asserted during CLEAR restarts from set 0.

Verification (N_WAY=4, NUM_SETS=4, INDEX_SIZE=2, TAG_SIZE=4)
REQ-029 Reset release -> req_ready=0 for 4 cycles, one resp_valid, then req_ready=1; all counters 0.
REQ-030 Read idx 1 tag 0xA, then read idx 1 tag 0xA -> miss way 0 resp_evict=0, then hit way 0; hit_cnt=1, miss_cnt=1, rd_cnt=2; each resp_valid exactly 2 cycles after acceptance.
REQ-031 Writes idx 2 tags 1,2,3,4, read tag 1, write tag 5 -> tags fill ways 0..3; tag-5 miss evicts way 2 (PLRU), resp_evict=1, resp_evict_dirty=1, resp_evict_tag=3.
REQ-032 Snoop invalidate idx 2 tag 5, then read idx 2 tag 6 -> first resp_hit=1; read allocates same way, resp_evict=0.
REQ-033 cmd 7 -> resp_err=1, counters and arrays unchanged; cmd 8 after traffic -> 4 CLEAR cycles, counters 0, subsequent read misses into way 0.
REQ-034 rst_n low during LOOKUP of an accepted request -> no response for that request; CLEAR restarts; rd_cnt=0.

Source files
------------

// File: rtl/cache_lookup.sv
// Set-associative tag lookup with tree-PLRU replacement, dirty tracking and saturating
// statistics; the tag arrays are zeroed by a one-set-per-cycle CLEAR walk.
module cache_lookup #(
   parameter  int NUM_SETS   = 16384,
   parameter  int N_WAY      = 16,
   parameter  int INDEX_SIZE = 14,
   parameter  int TAG_SIZE   = 12,
   parameter  int CNT_W      = 32,
   localparam int WAY_W      = $clog2(N_WAY)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_cmd,
   input  logic [INDEX_SIZE-1:0] req_index,
   input  logic [TAG_SIZE-1:0]   req_tag,
   output logic                  resp_valid,
   output logic                  resp_hit,
   output logic                  resp_err,
   output logic [WAY_W-1:0]      resp_way,
   output logic                  resp_evict,
   output logic                  resp_evict_dirty,
   output logic [TAG_SIZE-1:0]   resp_evict_tag,
   output logic [CNT_W-1:0]      hit_cnt,
   output logic [CNT_W-1:0]      miss_cnt,
   output logic [CNT_W-1:0]      rd_cnt,
   output logic [CNT_W-1:0]      wr_cnt
);

   localparam int PLRU_W = N_WAY - 1;
   localparam int NODE_W = (PLRU_W > 1) ? $clog2(PLRU_W) : 1;
   localparam logic [3:0] CMD_WR  = 4'd1;
   localparam logic [3:0] CMD_IRD = 4'd2;
   localparam logic [3:0] CMD_SNP = 4'd3;
   localparam logic [3:0] CMD_CLR = 4'd8;
   localparam logic [INDEX_SIZE-1:0] LAST_SET = INDEX_SIZE'(NUM_SETS - 1);

   typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, CLEAR} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cmd_q;
   logic [INDEX_SIZE-1:0] index_q, clr_set;
   logic [TAG_SIZE-1:0]   tag_q;
   logic                  accept;

   logic [N_WAY-1:0]    valid_arr [NUM_SETS];
   logic [N_WAY-1:0]    dirty_arr [NUM_SETS];
   logic [TAG_SIZE-1:0] tag_arr   [NUM_SETS][N_WAY];
   logic [PLRU_W-1:0]   plru_arr  [NUM_SETS];

   logic                lk_hit, lk_err, lk_evict, lk_evict_dirty;
   logic [WAY_W-1:0]    lk_way;
   logic [TAG_SIZE-1:0] lk_evict_tag;

   logic                is_access, is_snoop, is_err, hit, inv_found, evicting;
   logic [N_WAY-1:0]    set_valid, set_dirty, match;
   logic [PLRU_W-1:0]   set_plru, plru_touched;
   logic [WAY_W-1:0]    hit_way, inv_way, victim, alloc_way;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign is_access = (cmd_q <= CMD_IRD);
   assign is_snoop  = (cmd_q == CMD_SNP);
   assign is_err    = (cmd_q > CMD_SNP);
   assign evicting  = is_access && !hit && !inv_found;

   // Tag compare, lowest invalid way and PLRU victim for the registered set.
   // NOTE: every combinational output gets a default before any branch so no latch is inferred.
   always_comb begin
      int n_match;
      int node;
      set_valid = valid_arr[index_q];
      set_dirty = dirty_arr[index_q];
      set_plru  = plru_arr[index_q];
      match     = '0;
      hit_way   = '0;
      inv_way   = '0;
      inv_found = 1'b0;
      n_match   = 0;
      for (int w = N_WAY - 1; w >= 0; w--) begin
         match[w] = set_valid[w] && (tag_arr[index_q][w] == tag_q);
         if (match[w]) begin
            hit_way = WAY_W'(w);
            n_match++;
         end
         if (!set_valid[w]) begin
            inv_way   = WAY_W'(w);
            inv_found = 1'b1;
         end
      end
      hit  = (n_match == 1);
      node = 0;
      for (int l = 0; l < WAY_W; l++)
         node = 2 * node + 1 + int'(set_plru[NODE_W'(node)]);
      victim    = WAY_W'(node - PLRU_W);
      alloc_way = inv_found ? inv_way : victim;
   end

   // Point every node on the accessed way's path away from it.
   always_comb begin
      int node;
      logic [WAY_W-1:0] path;
      plru_touched = set_plru;
      path         = '0;
      node         = 0;
      for (int l = 0; l < WAY_W; l++) begin
         path = lk_way >> (WAY_W - 1 - l);
         plru_touched[NODE_W'(node)] = ~path[0];
         node = 2 * node + 1 + int'(path[0]);
      end
   end

   always_comb begin
      state_nxt        = state;
      accept           = 1'b0;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_hit         = 1'b0;
      resp_err         = 1'b0;
      resp_way         = '0;
      resp_evict       = 1'b0;
      resp_evict_dirty = 1'b0;
      resp_evict_tag   = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = (req_cmd == CMD_CLR) ? CLEAR : LOOKUP;
            end
         end
         LOOKUP: state_nxt = UPDATE;
         UPDATE: begin
            state_nxt  = IDLE;
            resp_valid = 1'b1;
            if (cmd_q != CMD_CLR) begin
               resp_hit         = lk_hit;
               resp_err         = lk_err;
               resp_way         = lk_way;
               resp_evict       = lk_evict;
               resp_evict_dirty = lk_evict_dirty;
               resp_evict_tag   = lk_evict_tag;
            end
         end
         CLEAR:   if (clr_set == LAST_SET) state_nxt = UPDATE;
         default: state_nxt = CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= CLEAR;
         clr_set        <= '0;
         cmd_q          <= CMD_CLR;
         index_q        <= '0;
         tag_q          <= '0;
         lk_hit         <= 1'b0;
         lk_err         <= 1'b0;
         lk_way         <= '0;
         lk_evict       <= 1'b0;
         lk_evict_dirty <= 1'b0;
         lk_evict_tag   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cmd_q   <= req_cmd;
            index_q <= req_index;
            tag_q   <= req_tag;
            clr_set <= '0;
         end
         if (state == CLEAR) clr_set <= clr_set + 1'b1;
         if (state == LOOKUP) begin
            lk_err         <= is_err;
            lk_hit         <= hit && !is_err;
            lk_evict       <= evicting;
            lk_evict_dirty <= evicting && set_dirty[victim];
            lk_evict_tag   <= evicting ? tag_arr[index_q][victim] : '0;
            if (hit && !is_err) lk_way <= hit_way;
            else if (is_access) lk_way <= alloc_way;
            else                lk_way <= '0;
         end
      end
   end

   // NOTE: the arrays have no reset term; the CLEAR walk that reset always enters zeroes them.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            valid_arr[clr_set] <= '0;
            dirty_arr[clr_set] <= '0;
            plru_arr[clr_set]  <= '0;
            for (int w = 0; w < N_WAY; w++) tag_arr[clr_set][w] <= '0;
         end else if (state == UPDATE) begin
            if (is_access) begin
               valid_arr[index_q][lk_way] <= 1'b1;
               tag_arr[index_q][lk_way]   <= tag_q;
               plru_arr[index_q]          <= plru_touched;
               if (cmd_q == CMD_WR) dirty_arr[index_q][lk_way] <= 1'b1;
               else if (!lk_hit)    dirty_arr[index_q][lk_way] <= 1'b0;
            end else if (is_snoop && lk_hit) begin
               valid_arr[index_q][lk_way] <= 1'b0;
               dirty_arr[index_q][lk_way] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || (state == CLEAR && clr_set == LAST_SET)) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
      end else if (state == UPDATE && is_access) begin
         if (cmd_q == CMD_WR) wr_cnt <= sat_inc(wr_cnt);
         else                 rd_cnt <= sat_inc(rd_cnt);
         if (lk_hit) hit_cnt  <= sat_inc(hit_cnt);
         else        miss_cnt <= sat_inc(miss_cnt);
      end
   end

endmodule

// File: tb/tb_cache_lookup.sv
// Directed bench for cache_lookup on a 4-set, 4-way configuration with 4-bit counters.
module tb_cache_lookup;

   localparam int NUM_SETS = 4, N_WAY = 4, INDEX_SIZE = 2, TAG_SIZE = 4, CNT_W = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [3:0] req_cmd = '0;
   logic [1:0] req_index = '0;
   logic [3:0] req_tag = '0;
   logic       req_ready, resp_valid, resp_hit, resp_err, resp_evict, resp_evict_dirty;
   logic [1:0] resp_way;
   logic [3:0] resp_evict_tag;
   logic [3:0] hit_cnt, miss_cnt, rd_cnt, wr_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int busy, resps;
   logic       r_hit, r_err, r_evict, r_evict_dirty;
   logic [1:0] r_way;
   logic [3:0] r_evict_tag;

   cache_lookup #(
      .NUM_SETS(NUM_SETS), .N_WAY(N_WAY), .INDEX_SIZE(INDEX_SIZE),
      .TAG_SIZE(TAG_SIZE), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_index(req_index), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err),
      .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_dirty(resp_evict_dirty),
      .resp_evict_tag(resp_evict_tag),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_counters(input string tag, input int h, input int m, input int r, input int w);
      check({tag, "_hit_cnt"},  hit_cnt,  h);
      check({tag, "_miss_cnt"}, miss_cnt, m);
      check({tag, "_rd_cnt"},   rd_cnt,   r);
      check({tag, "_wr_cnt"},   wr_cnt,   w);
   endtask

   // One request: accept, quiet LOOKUP cycle, response strobe, then ready again.
   task automatic do_req(input logic [3:0] c, input logic [1:0] i, input logic [3:0] t);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_req", req_ready, 1);
      req_valid = 1'b1;
      req_cmd   = c;
      req_index = i;
      req_tag   = t;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("lookup_no_resp", resp_valid, 0);
      check("lookup_quiet", {resp_hit, resp_err, resp_evict, resp_evict_dirty, resp_way, resp_evict_tag}, 0);
      @(negedge clk);
      check("resp_at_2", resp_valid, 1);
      r_hit         = resp_hit;
      r_err         = resp_err;
      r_way         = resp_way;
      r_evict       = resp_evict;
      r_evict_dirty = resp_evict_dirty;
      r_evict_tag   = resp_evict_tag;
      @(negedge clk);
      check("resp_one_cycle", resp_valid, 0);
      check("ready_after_resp", req_ready, 1);
   endtask

   // Called at a negedge while CLEAR runs; counts busy cycles and response strobes.
   task automatic wait_clear(output int n_busy, output int n_resp);
      int n;
      n_busy = 0;
      n_resp = 0;
      n      = 0;
      while (!req_ready && n < 40) begin
         if (resp_valid) begin
            n_resp++;
            check("clear_resp_hit", resp_hit, 0);
            check("clear_resp_err", resp_err, 0);
         end else if (n_resp == 0) begin
            n_busy++;
         end
         @(negedge clk);
         n++;
      end
      check("clear_done", req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset release: four CLEAR cycles, one strobe, then ready.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_clear(busy, resps);
      check("reset_busy_cycles", busy, 4);
      check("reset_resp_count", resps, 1);
      check_counters("reset", 0, 0, 0, 0);

      // Read miss then hit on the same line.
      do_req(4'd0, 2'd1, 4'hA);
      check("rd1_hit", r_hit, 0);
      check("rd1_way", r_way, 0);
      check("rd1_evict", r_evict, 0);
      check("rd1_err", r_err, 0);
      do_req(4'd0, 2'd1, 4'hA);
      check("rd2_hit", r_hit, 1);
      check("rd2_way", r_way, 0);
      check_counters("hitmiss", 1, 1, 2, 0);

      // Fill set 2 with dirty lines, touch way 0, then force a PLRU eviction.
      for (int k = 0; k < 4; k++) begin
         do_req(4'd1, 2'd2, 4'(k + 1));
         check("fill_way", r_way, k);
         check("fill_no_evict", r_evict, 0);
      end
      do_req(4'd0, 2'd2, 4'h1);
      check("touch_hit", r_hit, 1);
      check("touch_way", r_way, 0);
      do_req(4'd1, 2'd2, 4'h5);
      check("evict_hit", r_hit, 0);
      check("evict_way", r_way, 2);
      check("evict_flag", r_evict, 1);
      check("evict_dirty", r_evict_dirty, 1);
      check("evict_tag", r_evict_tag, 3);
      check_counters("fill", 2, 6, 3, 5);

      // Snoop invalidate frees way 2; the next miss reuses it without eviction.
      do_req(4'd3, 2'd2, 4'h5);
      check("snoop_hit", r_hit, 1);
      check("snoop_way", r_way, 2);
      check_counters("snoop", 2, 6, 3, 5);
      do_req(4'd0, 2'd2, 4'h6);
      check("realloc_hit", r_hit, 0);
      check("realloc_way", r_way, 2);
      check("realloc_evict", r_evict, 0);

      // PLRU now points at way 1 (dirty tag 2), then at way 2 (clean tag 6).
      do_req(4'd0, 2'd2, 4'h4);
      check("hit_way3", r_way, 3);
      check("hit_way3_hit", r_hit, 1);
      do_req(4'd1, 2'd2, 4'h7);
      check("evict2_way", r_way, 1);
      check("evict2_dirty", r_evict_dirty, 1);
      check("evict2_tag", r_evict_tag, 2);
      do_req(4'd0, 2'd2, 4'h8);
      check("evict3_way", r_way, 2);
      check("evict3_flag", r_evict, 1);
      check("evict3_dirty", r_evict_dirty, 0);
      check("evict3_tag", r_evict_tag, 6);
      check_counters("plru", 3, 9, 6, 6);

      // Unsupported command: error only, nothing changes.
      do_req(4'd7, 2'd2, 4'h4);
      check("err_flag", r_err, 1);
      check("err_hit", r_hit, 0);
      check("err_evict", r_evict, 0);
      check_counters("err", 3, 9, 6, 6);
      do_req(4'd0, 2'd2, 4'h4);
      check("post_err_hit", r_hit, 1);
      check("post_err_way", r_way, 3);
      do_req(4'd3, 2'd2, 4'h6);
      check("snoop_miss_hit", r_hit, 0);
      check_counters("snoop_miss", 4, 9, 7, 6);

      // Clear command wipes arrays and counters.
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = 4'd8;
      req_index = 2'd0;
      req_tag   = 4'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      wait_clear(busy, resps);
      check("clr_busy_cycles", busy, 4);
      check("clr_resp_count", resps, 1);
      check_counters("clr", 0, 0, 0, 0);
      do_req(4'd0, 2'd1, 4'hA);
      check("post_clr_hit", r_hit, 0);
      check("post_clr_way", r_way, 0);
      check("post_clr_evict", r_evict, 0);

      // Counters saturate at all-ones instead of wrapping.
      for (int k = 0; k < 20; k++) do_req(4'd0, 2'd0, 4'h1);
      check_counters("sat", 15, 2, 15, 0);

      // Reset during LOOKUP aborts the request and restarts CLEAR.
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = 4'd0;
      req_index = 2'd3;
      req_tag   = 4'h9;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
      check("abort_ready_low", req_ready, 0);
      rst_n = 1'b1;
      wait_clear(busy, resps);
      check("abort_busy_cycles", busy, 4);
      check("abort_resp_count", resps, 1);
      check_counters("abort", 0, 0, 0, 0);
      do_req(4'd0, 2'd1, 4'hA);
      check("post_abort_hit", r_hit, 0);
      check("post_abort_way", r_way, 0);
      check("post_abort_rd_cnt", rd_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
